// File: rtl/rx_word_aligner.sv
// rx_word_aligner: finds a sync pattern at any bit offset in the deserialized word stream.
// It locks after LOCK_COUNT consecutive hits at one offset, then emits realigned words.
// Bit 0 of every word is the earliest received bit.
module rx_word_aligner #(
  parameter int unsigned       WIDTH        = 16,
  parameter logic [WIDTH-1:0]  SYNC_PATTERN = 16'hA5F0,
  parameter int unsigned       LOCK_COUNT   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  input  logic                     realign,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     locked,
  output logic [$clog2(WIDTH)-1:0] shift
);

  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned CntW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    StSearch = 2'b00,
    StVerify = 2'b01,
    StLocked = 2'b10
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   prev_q;
  logic [CntW-1:0]    cnt_q;
  logic [ShW-1:0]     shift_q;
  logic [WIDTH-1:0]   dout_q;
  logic               dout_valid_q;
  logic               locked_q;

  logic [2*WIDTH-1:0] cat;
  logic [WIDTH-1:0]   win_sel;
  logic [CntW-1:0]    cnt_inc;
  logic               hit;
  logic [ShW-1:0]     hit_idx;

  // Previous word sits in the low half so window(s) slides forward in time as s grows.
  assign cat     = {din, prev_q};
  assign win_sel = cat[shift_q +: WIDTH];
  assign cnt_inc = cnt_q + CntW'(1);

  // Priority search over all offsets; scanning downward leaves the lowest match selected.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int s = int'(WIDTH) - 1; s >= 0; s--) begin
      if (cat[s +: WIDTH] == SYNC_PATTERN) begin
        hit     = 1'b1;
        hit_idx = ShW'(s);
      end
    end
  end

  // Alignment FSM with registered outputs; realign overrides any match in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StSearch;
      prev_q       <= '0;
      cnt_q        <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (din_valid) begin
        prev_q <= din;
      end
      if (realign) begin
        state_q  <= StSearch;
        cnt_q    <= '0;
        locked_q <= 1'b0;
      end else if (din_valid) begin
        case (state_q)
          StVerify: begin
            if (win_sel == SYNC_PATTERN) begin
              if (cnt_inc == CntW'(LOCK_COUNT)) begin
                state_q  <= StLocked;
                cnt_q    <= '0;
                locked_q <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              // The failing word is not re-searched; the next valid word starts afresh.
              state_q <= StSearch;
              cnt_q   <= '0;
            end
          end
          StLocked: begin
            dout_q       <= win_sel;
            dout_valid_q <= 1'b1;
          end
          default: begin
            // Covers StSearch and the unused encoding.
            state_q  <= StSearch;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            if (hit) begin
              shift_q <= hit_idx;
              if (LOCK_COUNT == 1) begin
                state_q  <= StLocked;
                locked_q <= 1'b1;
              end else begin
                state_q <= StVerify;
                cnt_q   <= CntW'(1);
              end
            end
          end
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign locked     = locked_q;
  assign shift      = shift_q;

endmodule

// File: tb/tb_rx_word_aligner.sv
// Bench for rx_word_aligner: an 8-bit / LOCK_COUNT=4 instance and a 16-bit / LOCK_COUNT=1
// instance. Expected aligned words are queued by the stimulus and popped by a monitor.
module tb_rx_word_aligner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: WIDTH=8, SYNC_PATTERN=8'hB4, LOCK_COUNT=4
  logic [7:0] a_din = '0;
  logic       a_din_valid = 1'b0;
  logic       a_realign = 1'b0;
  logic       a_rst = 1'b1;
  logic [7:0] a_dout;
  logic       a_dout_valid;
  logic       a_locked;
  logic [2:0] a_shift;

  // Instance B: WIDTH=16, SYNC_PATTERN=16'hA5F0, LOCK_COUNT=1
  logic [15:0] b_din = '0;
  logic        b_din_valid = 1'b0;
  logic        b_realign = 1'b0;
  logic        b_rst = 1'b1;
  logic [15:0] b_dout;
  logic        b_dout_valid;
  logic        b_locked;
  logic [3:0]  b_shift;

  rx_word_aligner #(
    .WIDTH       (8),
    .SYNC_PATTERN(8'hB4),
    .LOCK_COUNT  (4)
  ) u_dut_a (
    .clk       (clk),
    .rst       (a_rst),
    .din       (a_din),
    .din_valid (a_din_valid),
    .realign   (a_realign),
    .dout      (a_dout),
    .dout_valid(a_dout_valid),
    .locked    (a_locked),
    .shift     (a_shift)
  );

  rx_word_aligner #(
    .WIDTH       (16),
    .SYNC_PATTERN(16'hA5F0),
    .LOCK_COUNT  (1)
  ) u_dut_b (
    .clk       (clk),
    .rst       (b_rst),
    .din       (b_din),
    .din_valid (b_din_valid),
    .realign   (b_realign),
    .dout      (b_dout),
    .dout_valid(b_dout_valid),
    .locked    (b_locked),
    .shift     (b_shift)
  );

  logic [7:0]  q_a[$];
  logic [15:0] q_b[$];
  logic [7:0]  exp_a;
  logic [15:0] exp_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Apply one cycle of inputs, then return 1 time unit after the active edge.
  task automatic a_cyc(input logic [7:0] d, input logic v, input logic ra, input logic r);
    a_din = d; a_din_valid = v; a_realign = ra; a_rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic b_cyc(input logic [15:0] d, input logic v, input logic ra, input logic r);
    b_din = d; b_din_valid = v; b_realign = ra; b_rst = r;
    @(posedge clk);
    #1;
  endtask

  // Monitors: every presented word must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (a_dout_valid === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_dout_valid", 32'd1, 32'd0);
      end else begin
        exp_a = q_a.pop_front();
        chk("a_dout", {24'd0, a_dout}, {24'd0, exp_a});
      end
    end
  end

  always @(negedge clk) begin
    if (b_dout_valid === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_dout_valid", 32'd1, 32'd0);
      end else begin
        exp_b = q_b.pop_front();
        chk("b_dout", {16'd0, b_dout}, {16'd0, exp_b});
      end
    end
  end

  initial begin
    // ---------------- Instance A ----------------
    a_cyc(8'h00, 1'b0, 1'b0, 1'b1);
    a_cyc(8'h00, 1'b0, 1'b0, 1'b1);
    chk("a_rst_locked", {31'd0, a_locked}, 32'd0);
    chk("a_rst_dout_valid", {31'd0, a_dout_valid}, 32'd0);
    chk("a_rst_dout", {24'd0, a_dout}, 32'd0);
    chk("a_rst_shift", {29'd0, a_shift}, 32'd0);

    // Lock at offset 3 on a constant A5 stream.
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("a_w1_shift", {29'd0, a_shift}, 32'd0);
    chk("a_w1_locked", {31'd0, a_locked}, 32'd0);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("a_w2_shift", {29'd0, a_shift}, 32'd3);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("a_w4_locked", {31'd0, a_locked}, 32'd0);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("a_w5_locked", {31'd0, a_locked}, 32'd1);
    chk("a_w5_dout_valid", {31'd0, a_dout_valid}, 32'd0);

    // Data after lock: {3C,A5}>>3 = 94, {A5,3C}>>3 = A7, {A5,A5}>>3 = B4.
    q_a.push_back(8'h94);
    a_cyc(8'h3C, 1'b1, 1'b0, 1'b0);
    chk("a_data_shift", {29'd0, a_shift}, 32'd3);
    q_a.push_back(8'hA7);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    q_a.push_back(8'hB4);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);

    // realign with a matching word: back to SEARCH, so relock takes 4 more A5 words.
    a_cyc(8'hA5, 1'b1, 1'b1, 1'b0);
    chk("a_realign_locked", {31'd0, a_locked}, 32'd0);
    chk("a_realign_dout_valid", {31'd0, a_dout_valid}, 32'd0);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("a_realign_w3_locked", {31'd0, a_locked}, 32'd0);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("a_realign_w4_locked", {31'd0, a_locked}, 32'd1);
    q_a.push_back(8'h94);
    a_cyc(8'h3C, 1'b1, 1'b0, 1'b0);

    // rst while LOCKED clears everything, including a non-zero dout.
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b1);
    chk("a_rstlk_dout", {24'd0, a_dout}, 32'd0);
    chk("a_rstlk_locked", {31'd0, a_locked}, 32'd0);
    chk("a_rstlk_shift", {29'd0, a_shift}, 32'd0);
    chk("a_rstlk_dout_valid", {31'd0, a_dout_valid}, 32'd0);

    // VERIFY failure, then a full 5-word relock.
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    a_cyc(8'h00, 1'b1, 1'b0, 1'b0);
    chk("a_vfail_locked", {31'd0, a_locked}, 32'd0);
    for (int i = 0; i < 4; i++) a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("a_vfail_w4_locked", {31'd0, a_locked}, 32'd0);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("a_vfail_w5_locked", {31'd0, a_locked}, 32'd1);

    // rst mid-VERIFY.
    a_cyc(8'h00, 1'b0, 1'b0, 1'b1);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("a_midv_shift_before", {29'd0, a_shift}, 32'd3);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b1);
    chk("a_midv_shift", {29'd0, a_shift}, 32'd0);
    chk("a_midv_locked", {31'd0, a_locked}, 32'd0);
    chk("a_midv_dout", {24'd0, a_dout}, 32'd0);
    chk("a_midv_dout_valid", {31'd0, a_dout_valid}, 32'd0);

    // din_valid gaps carrying junk 00: prev must ignore them.
    for (int i = 0; i < 5; i++) begin
      a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
      a_cyc(8'h00, 1'b0, 1'b0, 1'b0);
      if (i == 3) chk("a_gap_w4_locked", {31'd0, a_locked}, 32'd0);
      if (i == 4) chk("a_gap_w5_locked", {31'd0, a_locked}, 32'd1);
    end
    q_a.push_back(8'hB4);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    a_cyc(8'h00, 1'b0, 1'b0, 1'b0);
    chk("a_gap_dout_valid", {31'd0, a_dout_valid}, 32'd0);
    chk("a_gap_dout_hold", {24'd0, a_dout}, 32'hB4);
    q_a.push_back(8'hB4);
    a_cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    a_cyc(8'h00, 1'b0, 1'b0, 1'b0);

    // ---------------- Instance B ----------------
    b_cyc(16'h0000, 1'b0, 1'b0, 1'b1);
    b_cyc(16'h0000, 1'b0, 1'b0, 1'b1);
    chk("b_rst_locked", {31'd0, b_locked}, 32'd0);
    chk("b_rst_shift", {28'd0, b_shift}, 32'd0);
    // {52F8,0000} holds A5F0 only at offset 15.
    b_cyc(16'h52F8, 1'b1, 1'b0, 1'b0);
    chk("b_lock_locked", {31'd0, b_locked}, 32'd1);
    chk("b_lock_shift", {28'd0, b_shift}, 32'd15);
    chk("b_lock_dout_valid", {31'd0, b_dout_valid}, 32'd0);
    // window(15) = {din[14:0], prev[15]}
    q_b.push_back(16'h2468);
    b_cyc(16'h1234, 1'b1, 1'b0, 1'b0);
    q_b.push_back(16'hFFFE);
    b_cyc(16'hFFFF, 1'b1, 1'b0, 1'b0);
    q_b.push_back(16'h0001);
    b_cyc(16'h0000, 1'b1, 1'b0, 1'b0);
    b_cyc(16'h0000, 1'b0, 1'b0, 1'b0);
    b_cyc(16'h0000, 1'b0, 1'b0, 1'b0);

    chk("a_queue_drained", q_a.size(), 32'd0);
    chk("b_queue_drained", q_b.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
